// File: rtl/toggle_hs_pkg.sv
// toggle_hs_pkg: shared state type and limits for the toggle handshake sink.
package toggle_hs_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, VALID} state_t;
    localparam int SETTLE_MAX = 15;
endpackage

// File: rtl/toggle_handshake_sink.sv
// toggle_handshake_sink: destination half of a toggle CDC handshake; detects a request
// toggle, waits SETTLE cycles for the source data to settle, captures it and returns an ack toggle.
module toggle_handshake_sink
    import toggle_hs_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int SETTLE = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_req_tgl,
    input  logic [WIDTH-1:0] io_data,
    output logic             io_ack_tgl,
    output logic             io_deq_valid,
    input  logic             io_deq_ready,
    output logic [WIDTH-1:0] io_deq_bits,
    output logic             io_busy,
    output logic             io_err
);
    if (SETTLE < 1 || SETTLE > SETTLE_MAX) begin : g_bad_settle
        $error("toggle_handshake_sink: SETTLE must be in 1..15");
    end

    state_t     r_state;
    logic [3:0] r_cnt;
    logic       r_req_seen;
    logic       w_edge;

    assign w_edge  = io_req_tgl ^ r_req_seen;
    assign io_busy = (r_state != IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_req_seen   <= 1'b0;
            io_ack_tgl   <= 1'b0;
            io_deq_valid <= 1'b0;
            io_deq_bits  <= '0;
            io_err       <= 1'b0;
        end else begin
            // a toggle while a transfer is in flight is a source protocol violation
            if (r_state != IDLE && w_edge) io_err <= 1'b1;
            case (r_state)
                IDLE: if (w_edge) begin
                    r_state    <= WAIT;
                    r_req_seen <= io_req_tgl;
                    r_cnt      <= 4'(SETTLE - 1);
                end
                WAIT: if (r_cnt == 4'd0) begin
                    io_deq_bits  <= io_data;
                    io_deq_valid <= 1'b1;
                    r_state      <= VALID;
                end else begin
                    r_cnt <= r_cnt - 4'd1;
                end
                VALID: if (io_deq_ready) begin
                    io_deq_valid <= 1'b0;
                    io_ack_tgl   <= ~io_ack_tgl;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_toggle_handshake_sink.sv
// tb_toggle_handshake_sink: three sinks (SETTLE 2, 1, 15) driven by toggle sources, checked
// every cycle against a timestamp-based transfer model plus directed literal expectations.
module tb_toggle_handshake_sink;
    logic        clock, reset;
    logic        req[3], ack[3], valid[3], ready[3], busy[3], err[3];
    logic [31:0] data[3], bits[3];

    int n_vec = 0, n_err = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        toggle_handshake_sink #(.WIDTH(32), .SETTLE(g == 0 ? 2 : (g == 1 ? 1 : 15))) u_dut (
            .clock(clock), .reset(reset), .io_req_tgl(req[g]), .io_data(data[g]),
            .io_ack_tgl(ack[g]), .io_deq_valid(valid[g]), .io_deq_ready(ready[g]),
            .io_deq_bits(bits[g]), .io_busy(busy[g]), .io_err(err[g])
        );
    end

    function automatic int sv(int k);
        return k == 0 ? 2 : (k == 1 ? 1 : 15);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
        end
    endtask

    // transfer model: a transfer is a timestamp of its accept cycle plus its word
    int          cyc;
    bit          m_pend[3], m_seen[3], m_ack[3], m_err[3], m_e;
    int          m_acc[3];
    logic [31:0] m_word[3], m_bits[3];

    initial forever begin
        @(posedge clock or negedge reset);
        if (!reset) begin
            cyc = 0;
            for (int k = 0; k < 3; k++) begin
                m_pend[k] = 0; m_seen[k] = 0; m_ack[k] = 0; m_err[k] = 0;
                m_acc[k] = 0; m_word[k] = 0; m_bits[k] = 0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                m_e = (req[k] != m_seen[k]);
                if (m_pend[k] && m_e) m_err[k] = 1;
                if (!m_pend[k]) begin
                    if (m_e) begin
                        m_pend[k] = 1; m_acc[k] = cyc; m_seen[k] = req[k]; m_word[k] = data[k];
                    end
                end else if (cyc == m_acc[k] + sv(k)) begin
                    m_bits[k] = m_word[k];
                end else if (cyc > m_acc[k] + sv(k) && ready[k]) begin
                    m_ack[k] = ~m_ack[k];
                    m_pend[k] = 0;
                end
            end
            cyc++;
        end
    end

    initial forever begin
        @(negedge clock);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("m%0d_valid", k), 32'(valid[k]), 32'(m_pend[k] && cyc >= m_acc[k] + sv(k) + 1));
            chk($sformatf("m%0d_busy", k), 32'(busy[k]), 32'(m_pend[k]));
            chk($sformatf("m%0d_ack", k), 32'(ack[k]), 32'(m_ack[k]));
            chk($sformatf("m%0d_err", k), 32'(err[k]), 32'(m_err[k]));
            chk($sformatf("m%0d_bits", k), bits[k], m_bits[k]);
        end
    end

    int first[3];
    bit got;

    initial begin
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req[k] = 0; ready[k] = 0; data[k] = '0;
        end
        repeat (3) @(negedge clock);
        chk("rst_valid", 32'(valid[0]), 0);
        chk("rst_busy", 32'(busy[0]), 0);
        chk("rst_ack", 32'(ack[0]), 0);
        chk("rst_bits", bits[0], 0);
        chk("rst_err", 32'(err[0]), 0);
        reset = 1'b1;
        @(negedge clock);
        // cycle 0: toggle all three sources at once
        for (int k = 0; k < 3; k++) begin
            data[k] = 32'hA5A5_0001; req[k] = 1; ready[k] = 1; first[k] = 0;
        end
        for (int c = 1; c <= 17; c++) begin
            @(negedge clock);
            for (int k = 0; k < 3; k++) if (valid[k] && first[k] == 0) first[k] = c;
            if (c == 1) begin
                chk("d_busy_c1", 32'(busy[0]), 1);
                chk("d_valid_c1", 32'(valid[0]), 0);
            end
            if (c == 3) chk("d_bits_c3", bits[0], 32'hA5A5_0001);
            if (c == 4) begin
                chk("d_ack_c4", 32'(ack[0]), 1);
                chk("d_busy_c4", 32'(busy[0]), 0);
                req[0] = 0; data[0] = 32'h2; ready[0] = 0;
            end
            if (c == 6) chk("b2b_valid_c6", 32'(valid[0]), 0);
            if (c == 7) chk("b2b_valid_c7", 32'(valid[0]), 1);
            if (c >= 8) begin
                chk("bp_valid", 32'(valid[0]), 1);
                chk("bp_bits", bits[0], 32'h2);
                chk("bp_ack", 32'(ack[0]), 1);
            end
        end
        chk("lat_s2", first[0], 3);
        chk("lat_s1", first[1], 2);
        chk("lat_s15", first[2], 16);
        ready[0] = 1;
        @(negedge clock);
        chk("bp_release_ack", 32'(ack[0]), 0);
        chk("bp_release_valid", 32'(valid[0]), 0);
        // violation: two toggles during WAIT on the SETTLE=2 sink
        req[0] = 1; data[0] = 32'h33;
        @(negedge clock); req[0] = 0;
        @(negedge clock); req[0] = 1;
        @(negedge clock);
        chk("viol_valid", 32'(valid[0]), 1);
        chk("viol_bits", bits[0], 32'h33);
        chk("viol_err", 32'(err[0]), 1);
        @(negedge clock);
        chk("viol_ack", 32'(ack[0]), 1);
        repeat (5) @(negedge clock);
        chk("viol_sticky", 32'(err[0]), 1);
        // randomized well-behaved sources
        repeat (3000) begin
            @(negedge clock);
            for (int k = 0; k < 3; k++) begin
                if (req[k] == ack[k] && $urandom_range(0, 2) == 0) begin
                    req[k] = ~req[k]; data[k] = $urandom;
                end
                ready[k] = ($urandom_range(0, 9) < 7);
            end
        end
        // park sink 0 in VALID, then reset it mid-cycle
        for (int k = 0; k < 3; k++) ready[k] = 0;
        if (req[0] == ack[0]) begin
            req[0] = ~req[0]; data[0] = 32'hDEAD_BEEF;
        end
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clock);
            got = valid[0];
        end
        chk("park_valid_timeout", 32'(got), 1);
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        chk("async_valid", 32'(valid[0]), 0);
        chk("async_busy", 32'(busy[0]), 0);
        chk("async_ack", 32'(ack[0]), 0);
        chk("async_bits", bits[0], 0);
        for (int k = 0; k < 3; k++) req[k] = 0;
        @(negedge clock);
        reset = 1'b1;
        repeat (5) begin
            @(negedge clock);
            chk("post_rst_idle", 32'(busy[0]), 0);
        end
        req[0] = 1; data[0] = 32'h77;
        @(negedge clock);
        chk("post_rst_edge_busy", 32'(busy[0]), 1);
        for (int k = 0; k < 3; k++) ready[k] = 1;
        repeat (20) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/toggle_handshake_sink.md
TOGGLE_HANDSHAKE_SINK -- requirements
Module: toggle_handshake_sink

Interface
REQ-001 Parameter WIDTH, default 32: width of the transferred data word.
REQ-002 Parameter SETTLE, default 2, legal range 1..15: cycles between request-edge detection and data capture.
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; asserting it (0) resets all state immediately, and deassertion is synchronous to clock.
REQ-005 io_req_tgl  input  1  request toggle, already synchronized into this clock domain by the upstream 3-stage synchronizer.
REQ-006 io_data  input  WIDTH  source-domain data word; stable from the source toggle until the matching ack toggle returns.
REQ-007 io_ack_tgl  output  1  registered acknowledge toggle returned to the source domain.
REQ-008 io_deq_valid  output  1  captured word available.
REQ-009 io_deq_ready  input  1  local consumer accepts the word.
REQ-010 io_deq_bits  output  WIDTH  captured word, registered.
REQ-011 io_busy  output  1  high whenever state is not IDLE.
REQ-012 io_err  output  1  sticky protocol-violation flag.

Function
REQ-013 The block SHALL hold a req_seen register; edge = io_req_tgl XOR req_seen.
REQ-014 The FSM SHALL have exactly three states: IDLE, WAIT and VALID.
REQ-015 IDLE, edge=1 at cycle 0: next state WAIT; req_seen <= io_req_tgl; cnt <= SETTLE-1.
REQ-016 WAIT: if cnt=0, capture io_data into io_deq_bits and go to VALID; otherwise cnt decrements. WAIT therefore lasts exactly SETTLE cycles.
REQ-017 io_deq_valid SHALL be 1 only in VALID, first asserted at cycle SETTLE+1 after the edge cycle.
REQ-018 VALID with io_deq_ready=1 at cycle H: handshake occurs; io_ack_tgl inverts and state is IDLE at H+1.
REQ-019 VALID with io_deq_ready=0: io_deq_valid and io_deq_bits SHALL remain unchanged.
REQ-020 io_deq_bits SHALL change only on capture; it holds its value in IDLE.
REQ-021 An edge in IDLE at cycle H+1 SHALL be accepted normally, giving back-to-back transfers without a dead cycle.
REQ-022 When state is WAIT or VALID and io_req_tgl differs from req_seen, io_err SHALL set and stay set until reset. The in-flight transfer continues unaffected, and req_seen is not updated.
REQ-023 cnt SHALL be 4 bits wide; SETTLE outside 1..15 is a compile-time error.
REQ-024 io_busy SHALL equal (state != IDLE), combinational from the state register.

Reset
REQ-025 While reset=0: state IDLE, cnt 0, req_seen 0, io_ack_tgl 0, io_deq_bits 0, io_deq_valid 0, io_busy 0, io_err 0.
REQ-026 Reset asserted mid-transfer SHALL discard the pending word with no ack; the source is reset together with this block.
REQ-027 After reset release with io_req_tgl=1, the first cycle SHALL count as an edge (req_seen=0).

Structure
REQ-028 Package toggle_hs_pkg SHALL hold the state enum typedef (IDLE, WAIT, VALID) and the constant SETTLE_MAX=15.
REQ-029 The block SHALL contain no sub-module; req/ack synchronizers are instantiated by the parent, and the source-side counterpart is a separate block.
REQ-030 All outputs SHALL be driven directly from registers, except io_busy (REQ-024).

Verification
REQ-031 SETTLE=2: io_data=0xA5A5_0001, io_req_tgl 0->1 at cycle 0, ready=1 -> valid at cycle 3 with bits 0xA5A5_0001; ack_tgl 0->1 at cycle 4; busy at cycles 1-3.
REQ-032 Backpressure: ready=0 for 10 cycles while valid -> bits and valid stable, ack_tgl unchanged; ready=1 -> ack toggles the next cycle.
REQ-033 Back-to-back: second toggle (1->0, data 0x2) presented at cycle H+1 -> accepted at H+1, valid at H+1+SETTLE+1, ack 1->0.
REQ-034 Violation: toggle req twice during WAIT -> io_err=1 and sticky; first word still delivered intact with one ack toggle.
REQ-035 Reset asserted asynchronously in VALID (mid-clock) -> valid, busy, ack_tgl and bits drop to 0 immediately; after release with req_tgl=0, the block stays IDLE.
REQ-036 SETTLE=1 and SETTLE=15 -> valid at exactly cycle 2 and cycle 16 respectively after the edge cycle.
